enc_stream_scheduler: RTL and testbench

- Shares one RS encoder input port among N_CH message streams at codeword granularity.
- Grants one channel per codeword by round-robin and forwards its message beats (ENC_SYM symbols per beat) to the encoder input.
- Sizes the final partial beat of each codeword and tags the beats with start/end markers.
- Records the grant order in a small FIFO so the parity/output side can route each finished codeword back to its channel.

---
 rtl/enc_stream_scheduler_pkg.sv | 18 +
 rtl/enc_order_fifo.sv | 98 +++++++++
 rtl/enc_stream_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_enc_stream_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_stream_scheduler_pkg.sv
// Shared definitions for the RS encoder input-side stream scheduler.
package enc_stream_scheduler_pkg;

  // Default symbol width, encoder beat width and codeword message length
  localparam int SYM_W       = 8;
  localparam int ENC_SYM     = 4;
  localparam int RSC_MES_LEN = 239;

  // Symbols carried by the final beat of a codeword (0 means a full beat)
  localparam int LAST_BEAT_SYM = RSC_MES_LEN % ENC_SYM;

  // Scheduler states
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } sch_state_e;

endpackage

// File: rtl/enc_order_fifo.sv
// Small synchronous FIFO that remembers the order in which channels were
// granted. The head is held in a register so downstream sees a flop output.
module enc_order_fifo #(
  parameter int W   = 2,
  parameter int DEP = 4,
  localparam int PW = $clog2(DEP),
  localparam int CW = $clog2(DEP + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  import enc_stream_scheduler_pkg::*;

  logic [W-1:0]  mem_q [DEP];
  logic [W-1:0]  mem_d [DEP];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic [W-1:0]  head_q, head_d;
  logic          do_push_s;
  logic          do_pop_s;

  // Pointer advance with wrap, valid for non-power-of-two depths
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(DEP - 1)) begin
      n = '0;
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  // Next-state computation for storage, pointers, occupancy and head
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    do_push_s = push & ~full_q;
    do_pop_s  = pop & ~empty_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    full_d  = (cnt_d == CW'(DEP));
    empty_d = (cnt_d == CW'(0));
    head_d  = mem_d[rd_ptr_d];
  end

  // State registers; the head, full and empty flags are all flop outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEP; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      head_q   <= head_d;
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign head  = head_q;

endmodule

// File: rtl/enc_stream_scheduler.sv
// Shares one RS encoder input among N_CH message streams. A channel is
// granted for a whole codeword (round-robin), its beats are forwarded with
// size and start/end markers, and the grant order is queued for the output
// side so finished codewords can be routed back to their channel.
module enc_stream_scheduler #(
  parameter int N_CH        = 4,
  parameter int SYM_W       = enc_stream_scheduler_pkg::SYM_W,
  parameter int ENC_SYM     = enc_stream_scheduler_pkg::ENC_SYM,
  parameter int RSC_MES_LEN = enc_stream_scheduler_pkg::RSC_MES_LEN,
  parameter int ORD_DEP     = 4,
  localparam int CH_W   = $clog2(N_CH),
  localparam int CNT_W  = $clog2(ENC_SYM + 1),
  localparam int BEAT_W = ENC_SYM * SYM_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_en,
  input  logic [N_CH-1:0]               ch_valid,
  input  logic [N_CH-1:0][BEAT_W-1:0]   ch_data,
  output logic [N_CH-1:0]               ch_ready,
  output logic                          enc_valid,
  input  logic                          enc_ready,
  output logic [BEAT_W-1:0]             enc_data,
  output logic [CNT_W-1:0]              enc_cnt,
  output logic                          enc_sof,
  output logic                          enc_eof,
  output logic [CH_W-1:0]               enc_ch,
  output logic                          ord_valid,
  output logic [CH_W-1:0]               ord_ch,
  input  logic                          ord_pop,
  output logic                          busy
);
  import enc_stream_scheduler_pkg::*;

  localparam int SCNT_W = $clog2(RSC_MES_LEN + 1);

  sch_state_e        state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [SCNT_W-1:0] sym_cnt_q, sym_cnt_d;

  logic [SCNT_W-1:0] rem_s;
  logic [CNT_W-1:0]  beat_cnt_s;
  logic              last_beat_s;
  logic              grant_ok_s;
  logic [CH_W-1:0]   winner_s;
  logic [CH_W-1:0]   winner_inc_s;
  logic              hs_s;
  logic              push_s;
  logic              ord_full_s;
  logic              ord_empty_s;
  logic [CH_W-1:0]   ord_head_s;

  // First requesting channel at or above ptr, wrapping past N_CH-1
  function automatic logic [CH_W-1:0] rr_pick(input logic [N_CH-1:0] req,
                                              input logic [CH_W-1:0] ptr);
    logic [2*N_CH-1:0] dbl;
    int                off;
    int                sum;
    dbl = {req, req} >> ptr;
    off = 0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        off = i;
      end else begin
        off = off;
      end
    end
    sum = int'(ptr) + off;
    if (sum >= N_CH) begin
      sum = sum - N_CH;
    end else begin
      sum = sum;
    end
    return CH_W'(sum);
  endfunction

  // Remaining message symbols and the size of the beat currently offered
  always_comb begin
    rem_s = SCNT_W'(RSC_MES_LEN) - sym_cnt_q;
    if (rem_s <= SCNT_W'(ENC_SYM)) begin
      beat_cnt_s  = CNT_W'(rem_s);
      last_beat_s = 1'b1;
    end else begin
      beat_cnt_s  = CNT_W'(ENC_SYM);
      last_beat_s = 1'b0;
    end
  end

  // Grant qualification and round-robin winner; full flag is registered
  always_comb begin
    grant_ok_s = cfg_en & (|ch_valid) & ~ord_full_s;
    winner_s   = rr_pick(ch_valid, rr_q);
    if (winner_s == CH_W'(N_CH - 1)) begin
      winner_inc_s = '0;
    end else begin
      winner_inc_s = winner_s + CH_W'(1);
    end
    hs_s = (state_q == S_XFER) & ch_valid[grant_q] & enc_ready;
  end

  // Encoder-side and channel-side outputs; all zero outside a transfer
  always_comb begin
    ch_ready  = '0;
    enc_valid = 1'b0;
    enc_data  = '0;
    enc_cnt   = '0;
    enc_sof   = 1'b0;
    enc_eof   = 1'b0;
    enc_ch    = '0;
    busy      = 1'b0;
    if (state_q == S_XFER) begin
      enc_valid         = ch_valid[grant_q];
      enc_data          = ch_data[grant_q];
      enc_cnt           = beat_cnt_s;
      enc_sof           = (sym_cnt_q == SCNT_W'(0));
      enc_eof           = last_beat_s;
      enc_ch            = grant_q;
      ch_ready[grant_q] = enc_ready;
      busy              = 1'b1;
    end else begin
      busy = 1'b0;
    end
  end

  // Next-state logic: grant from idle, count symbols, chain on the last beat
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    sym_cnt_d = sym_cnt_q;
    push_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_ok_s) begin
          state_d   = S_XFER;
          grant_d   = winner_s;
          rr_d      = winner_inc_s;
          sym_cnt_d = '0;
          push_s    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_XFER: begin
        if (hs_s && last_beat_s) begin
          if (grant_ok_s) begin
            state_d   = S_XFER;
            grant_d   = winner_s;
            rr_d      = winner_inc_s;
            sym_cnt_d = '0;
            push_s    = 1'b1;
          end else begin
            state_d   = S_IDLE;
            sym_cnt_d = '0;
          end
        end else if (hs_s) begin
          sym_cnt_d = sym_cnt_q + SCNT_W'(beat_cnt_s);
        end else begin
          sym_cnt_d = sym_cnt_q;
        end
      end
      default: begin
        state_d   = S_IDLE;
        sym_cnt_d = '0;
      end
    endcase
  end

  // Scheduler state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      sym_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      sym_cnt_q <= sym_cnt_d;
    end
  end

  enc_order_fifo #(
    .W   (CH_W),
    .DEP (ORD_DEP)
  ) u_order_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (winner_s),
    .pop       (ord_pop),
    .full      (ord_full_s),
    .empty     (ord_empty_s),
    .head      (ord_head_s)
  );

  assign ord_valid = ~ord_empty_s;
  assign ord_ch    = ord_head_s;

endmodule

// File: tb/tb_enc_stream_scheduler.sv
// Directed bench for enc_stream_scheduler with a 10-symbol codeword and
// 4-symbol beats, so each codeword is three beats of 4, 4 and 2 symbols.
module tb_enc_stream_scheduler;

  localparam int N_CH = 4;
  localparam int SYM_W = 8;
  localparam int ENC_SYM = 4;
  localparam int RSC_MES_LEN = 10;
  localparam int ORD_DEP = 4;

  logic                  clk;
  logic                  rst_n;
  logic                  cfg_en;
  logic [3:0]            ch_valid;
  logic [3:0][31:0]      ch_data;
  logic [3:0]            ch_ready;
  logic                  enc_valid;
  logic                  enc_ready;
  logic [31:0]           enc_data;
  logic [2:0]            enc_cnt;
  logic                  enc_sof;
  logic                  enc_eof;
  logic [1:0]            enc_ch;
  logic                  ord_valid;
  logic [1:0]            ord_ch;
  logic                  ord_pop;
  logic                  busy;

  int n_chk;
  int n_pass;
  int n_fail;

  enc_stream_scheduler #(
    .N_CH        (N_CH),
    .SYM_W       (SYM_W),
    .ENC_SYM     (ENC_SYM),
    .RSC_MES_LEN (RSC_MES_LEN),
    .ORD_DEP     (ORD_DEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_en    (cfg_en),
    .ch_valid  (ch_valid),
    .ch_data   (ch_data),
    .ch_ready  (ch_ready),
    .enc_valid (enc_valid),
    .enc_ready (enc_ready),
    .enc_data  (enc_data),
    .enc_cnt   (enc_cnt),
    .enc_sof   (enc_sof),
    .enc_eof   (enc_eof),
    .enc_ch    (enc_ch),
    .ord_valid (ord_valid),
    .ord_ch    (ord_ch),
    .ord_pop   (ord_pop),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cfg_en    = 1'b0;
    ch_valid  = 4'b0000;
    enc_ready = 1'b0;
    ord_pop   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic check_all_zero(input string pfx);
    check_val({pfx, "_busy"},      32'(busy),      32'd0);
    check_val({pfx, "_enc_valid"}, 32'(enc_valid), 32'd0);
    check_val({pfx, "_ch_ready"},  32'(ch_ready),  32'd0);
    check_val({pfx, "_enc_cnt"},   32'(enc_cnt),   32'd0);
    check_val({pfx, "_enc_sof"},   32'(enc_sof),   32'd0);
    check_val({pfx, "_enc_eof"},   32'(enc_eof),   32'd0);
    check_val({pfx, "_enc_ch"},    32'(enc_ch),    32'd0);
    check_val({pfx, "_ord_valid"}, 32'(ord_valid), 32'd0);
    check_val({pfx, "_ord_ch"},    32'(ord_ch),    32'd0);
  endtask

  initial begin
    int exp_ch [5];
    int exp_cnt [5];
    int exp_sof [5];
    int exp_eof [5];
    int rdy [5];
    int hs_n;
    int sof_n;

    n_chk  = 0;
    n_pass = 0;
    n_fail = 0;
    ch_data[0] = 32'h03020100;
    ch_data[1] = 32'h13121110;
    ch_data[2] = 32'h23222120;
    ch_data[3] = 32'h33323130;

    // Reset state and single-channel codeword
    do_reset();
    check_all_zero("rst");
    ch_valid  = 4'b0100;
    cfg_en    = 1'b1;
    enc_ready = 1'b1;
    settle();
    check_val("t1_idle_busy", 32'(busy), 32'd0);
    tick(); settle();
    check_val("t1_b1_busy",     32'(busy),      32'd1);
    check_val("t1_b1_valid",    32'(enc_valid), 32'd1);
    check_val("t1_b1_cnt",      32'(enc_cnt),   32'd4);
    check_val("t1_b1_sof",      32'(enc_sof),   32'd1);
    check_val("t1_b1_eof",      32'(enc_eof),   32'd0);
    check_val("t1_b1_ch",       32'(enc_ch),    32'd2);
    check_val("t1_b1_ready",    32'(ch_ready),  32'h4);
    check_val("t1_b1_data",     enc_data,       32'h23222120);
    check_val("t1_b1_ordv",     32'(ord_valid), 32'd1);
    check_val("t1_b1_ordch",    32'(ord_ch),    32'd2);
    tick(); settle();
    check_val("t1_b2_cnt",      32'(enc_cnt),   32'd4);
    check_val("t1_b2_sof",      32'(enc_sof),   32'd0);
    check_val("t1_b2_eof",      32'(enc_eof),   32'd0);
    tick();
    cfg_en = 1'b0;
    settle();
    check_val("t1_b3_cnt",      32'(enc_cnt),   32'd2);
    check_val("t1_b3_sof",      32'(enc_sof),   32'd0);
    check_val("t1_b3_eof",      32'(enc_eof),   32'd1);
    tick(); settle();
    check_val("t1_end_busy",    32'(busy),      32'd0);
    check_val("t1_end_valid",   32'(enc_valid), 32'd0);
    check_val("t1_end_ordv",    32'(ord_valid), 32'd1);
    check_val("t1_end_ordch",   32'(ord_ch),    32'd2);

    // All channels valid with pops every cycle: zero-bubble round robin
    do_reset();
    exp_ch = '{0, 1, 2, 3, 0};
    ch_valid  = 4'b1111;
    cfg_en    = 1'b1;
    enc_ready = 1'b1;
    ord_pop   = 1'b1;
    for (int cw = 0; cw < 5; cw++) begin
      for (int b = 0; b < 3; b++) begin
        tick(); settle();
        check_val($sformatf("t2_cw%0d_b%0d_busy", cw, b), 32'(busy), 32'd1);
        check_val($sformatf("t2_cw%0d_b%0d_ch", cw, b), 32'(enc_ch), 32'(exp_ch[cw]));
        check_val($sformatf("t2_cw%0d_b%0d_ready", cw, b), 32'(ch_ready), 32'(1 << exp_ch[cw]));
        check_val($sformatf("t2_cw%0d_b%0d_sof", cw, b), 32'(enc_sof), 32'(b == 0));
        check_val($sformatf("t2_cw%0d_b%0d_eof", cw, b), 32'(enc_eof), 32'(b == 2));
        if (b == 0) begin
          check_val($sformatf("t2_cw%0d_ordv", cw), 32'(ord_valid), 32'd1);
          check_val($sformatf("t2_cw%0d_ordch", cw), 32'(ord_ch), 32'(exp_ch[cw]));
        end
      end
    end

    // Encoder stalls on alternate cycles
    do_reset();
    rdy     = '{1, 0, 1, 0, 1};
    exp_cnt = '{4, 4, 4, 2, 2};
    exp_sof = '{1, 0, 0, 0, 0};
    exp_eof = '{0, 0, 0, 1, 1};
    hs_n = 0;
    ch_valid  = 4'b0001;
    cfg_en    = 1'b1;
    enc_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      enc_ready = rdy[k][0];
      if (k == 4) cfg_en = 1'b0;
      settle();
      check_val($sformatf("t3_k%0d_cnt", k), 32'(enc_cnt), 32'(exp_cnt[k]));
      check_val($sformatf("t3_k%0d_sof", k), 32'(enc_sof), 32'(exp_sof[k]));
      check_val($sformatf("t3_k%0d_eof", k), 32'(enc_eof), 32'(exp_eof[k]));
      check_val($sformatf("t3_k%0d_ready", k), 32'(ch_ready), 32'(rdy[k]));
      check_val($sformatf("t3_k%0d_data", k), enc_data, 32'h03020100);
      if (enc_valid && ch_ready[0]) hs_n++;
    end
    tick(); settle();
    check_val("t3_end_busy", 32'(busy), 32'd0);
    check_val("t3_hs_count", 32'(hs_n), 32'd3);

    // Order FIFO full blocks further grants until one pop
    do_reset();
    ch_valid  = 4'b1111;
    cfg_en    = 1'b1;
    enc_ready = 1'b1;
    sof_n = 0;
    for (int k = 0; k < 16; k++) begin
      tick(); settle();
      if (enc_valid && (ch_ready != 4'b0000) && enc_sof) sof_n++;
    end
    check_val("t4_grants",     32'(sof_n),     32'd4);
    check_val("t4_full_busy",  32'(busy),      32'd0);
    check_val("t4_full_ordv",  32'(ord_valid), 32'd1);
    check_val("t4_full_ordch", 32'(ord_ch),    32'd0);
    ord_pop = 1'b1;
    tick();
    ord_pop = 1'b0;
    settle();
    check_val("t4_pop_busy",   32'(busy),      32'd0);
    check_val("t4_pop_ordch",  32'(ord_ch),    32'd1);
    tick(); settle();
    check_val("t4_regrant_busy", 32'(busy),    32'd1);
    check_val("t4_regrant_ch",   32'(enc_ch),  32'd0);
    check_val("t4_regrant_sof",  32'(enc_sof), 32'd1);
    sof_n = 0;
    for (int k = 0; k < 5; k++) begin
      tick(); settle();
      if (enc_valid && enc_sof) sof_n++;
    end
    check_val("t4_no_more_grants", 32'(sof_n), 32'd0);
    check_val("t4_end_busy",       32'(busy),  32'd0);

    // cfg_en dropped after the first beat does not truncate the codeword
    do_reset();
    ch_valid  = 4'b0010;
    cfg_en    = 1'b1;
    enc_ready = 1'b1;
    settle();
    tick(); settle();
    check_val("t5_b1_sof", 32'(enc_sof), 32'd1);
    check_val("t5_b1_ch",  32'(enc_ch),  32'd1);
    tick();
    cfg_en = 1'b0;
    settle();
    check_val("t5_b2_busy", 32'(busy),    32'd1);
    check_val("t5_b2_cnt",  32'(enc_cnt), 32'd4);
    check_val("t5_b2_sof",  32'(enc_sof), 32'd0);
    tick(); settle();
    check_val("t5_b3_busy", 32'(busy),    32'd1);
    check_val("t5_b3_cnt",  32'(enc_cnt), 32'd2);
    check_val("t5_b3_eof",  32'(enc_eof), 32'd1);
    tick(); settle();
    check_val("t5_idle_busy", 32'(busy), 32'd0);
    tick(); tick(); tick(); settle();
    check_val("t5_hold_busy", 32'(busy), 32'd0);
    cfg_en = 1'b1;
    tick(); settle();
    check_val("t5_resume_busy", 32'(busy),    32'd1);
    check_val("t5_resume_sof",  32'(enc_sof), 32'd1);
    check_val("t5_resume_ch",   32'(enc_ch),  32'd1);

    // Asynchronous reset in the middle of a codeword
    do_reset();
    ch_valid  = 4'b0110;
    cfg_en    = 1'b1;
    enc_ready = 1'b1;
    settle();
    tick(); settle();
    check_val("t6_pre_ch", 32'(enc_ch), 32'd1);
    tick(); settle();
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    ch_valid = 4'b1111;
    tick();
    rst_n = 1'b1;
    settle();
    check_val("t6_rel_busy", 32'(busy), 32'd0);
    tick(); settle();
    check_val("t6_post_busy", 32'(busy),    32'd1);
    check_val("t6_post_ch",   32'(enc_ch),  32'd0);
    check_val("t6_post_sof",  32'(enc_sof), 32'd1);
    check_val("t6_post_cnt",  32'(enc_cnt), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
